// File: rtl/crank_wheel_gen.sv
// N-M crank trigger wheel generator with cam gating and ramped tooth period.
// Period changes only at slot boundaries; outputs decode registered state.
module crank_wheel_gen #(
    parameter int TEETH       = 60,
    parameter int MISSING     = 2,
    parameter int PW          = 16,
    parameter int TW          = 8,
    parameter int START_TOOTH = 45,
    parameter int PERIOD_RST  = 16,
    parameter int CAM_ON      = 4,
    parameter int CAM_OFF     = 54,
    parameter int CAM_TOGGLE  = 30
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          load,
    input  logic [PW-1:0] period_in,
    input  logic [PW-1:0] accel_in,
    input  logic [PW-1:0] period_min,
    input  logic [PW-1:0] period_max,
    output logic          vr_out,
    output logic          cam_out,
    output logic          gap_out,
    output logic          rev_pulse,
    output logic          cam_phase,
    output logic [TW-1:0] tooth_idx,
    output logic [PW-1:0] period_out
);

    typedef logic signed [PW+1:0] ext_t;

    localparam logic [TW-1:0] LAST_T   = TW'(TEETH - 1);
    localparam logic [TW-1:0] GAP_T    = TW'(TEETH - MISSING);
    localparam logic [TW-1:0] START_T  = TW'(START_TOOTH);
    localparam logic [TW-1:0] TOGGLE_T = TW'(CAM_TOGGLE);
    localparam logic [TW:0]   ON_T     = (TW+1)'(CAM_ON);
    localparam logic [TW:0]   OFF_T    = (TW+1)'(CAM_OFF);
    localparam logic [PW-1:0] P_RST    = PW'(PERIOD_RST);
    localparam ext_t          TWO      = ext_t'(2);

    logic [PW-1:0] slot_cnt;
    logic [PW-1:0] period;
    logic [TW-1:0] tooth;
    logic          pend;
    logic [PW-1:0] pend_val;
    logic          phase;
    logic          wrap_q;

    logic          boundary;
    logic [TW-1:0] tooth_nxt;
    logic [PW-1:0] period_nxt;
    logic [PW-1:0] ld_val;
    ext_t          base;
    ext_t          lo;
    ext_t          hi;
    ext_t          clamp;

    assign boundary  = ena && (slot_cnt == period - 1'b1);
    assign tooth_nxt = (tooth == LAST_T) ? '0 : tooth + 1'b1;

    // Saturating next period, evaluated wide so a large step cannot wrap.
    always_comb begin
        ld_val = load ? period_in : pend_val;
        if (load || pend)
            base = ext_t'({2'b00, ld_val});
        else
            base = ext_t'({2'b00, period})
                 + ext_t'({{2{accel_in[PW-1]}}, accel_in});
        lo = ext_t'({2'b00, period_min});
        if (lo < TWO)
            lo = TWO;
        hi = ext_t'({2'b00, period_max});
        clamp = base;
        if (clamp < lo)
            clamp = lo;
        if (clamp > hi)
            clamp = hi;
        if (clamp < TWO)
            clamp = TWO;
        period_nxt = clamp[PW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt <= '0;
            period   <= P_RST;
            tooth    <= START_T;
            pend     <= 1'b0;
            pend_val <= '0;
            phase    <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            if (load) begin
                pend     <= 1'b1;
                pend_val <= period_in;
            end
            if (boundary) begin
                slot_cnt <= '0;
                tooth    <= tooth_nxt;
                period   <= period_nxt;
                pend     <= 1'b0;
                wrap_q   <= (tooth == LAST_T);
                if (tooth_nxt == TOGGLE_T)
                    phase <= ~phase;
            end else if (ena) begin
                slot_cnt <= slot_cnt + 1'b1;
                wrap_q   <= 1'b0;
            end
        end
    end

    assign gap_out    = (tooth >= GAP_T);
    assign vr_out     = (slot_cnt >= (period >> 1)) && !gap_out;
    assign rev_pulse  = wrap_q && (tooth == '0) && (slot_cnt == '0);
    assign cam_out    = phase && ({1'b0, tooth} >= ON_T)
                      && ({1'b0, tooth} < OFF_T);
    assign cam_phase  = phase;
    assign tooth_idx  = tooth;
    assign period_out = period;

endmodule

// File: tb/tb_crank_wheel_gen.sv
// Randomised bench for crank_wheel_gen against a slot-level behavioural model.
// Directed phases cover wheel timing, clamps, load priority, cam, freeze and reset.
module tb_crank_wheel_gen;

    localparam int TEETH   = 60;
    localparam int MISSING = 2;
    localparam int PW      = 16;
    localparam int TW      = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          ena;
    logic          load;
    logic [PW-1:0] period_in;
    logic [PW-1:0] accel_in;
    logic [PW-1:0] period_min;
    logic [PW-1:0] period_max;
    logic          vr_out;
    logic          cam_out;
    logic          gap_out;
    logic          rev_pulse;
    logic          cam_phase;
    logic [TW-1:0] tooth_idx;
    logic [PW-1:0] period_out;

    crank_wheel_gen dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .load       (load),
        .period_in  (period_in),
        .accel_in   (accel_in),
        .period_min (period_min),
        .period_max (period_max),
        .vr_out     (vr_out),
        .cam_out    (cam_out),
        .gap_out    (gap_out),
        .rev_pulse  (rev_pulse),
        .cam_phase  (cam_phase),
        .tooth_idx  (tooth_idx),
        .period_out (period_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input longint obs,
                         input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Model: position inside the wheel as plain integers.
    int m_slot, m_tooth, m_per, m_pend, m_pv, m_phase, m_prev;

    function automatic int sat(input int x);
        int lo, r;
        lo = (int'(period_min) < 2) ? 2 : int'(period_min);
        r = x;
        if (r < lo) r = lo;
        if (r > int'(period_max)) r = int'(period_max);
        if (r < 2) r = 2;
        return r;
    endfunction

    task automatic model_step();
        int a;
        if (rst) begin
            m_slot = 0; m_tooth = 45; m_per = 16;
            m_pend = 0; m_pv = 0; m_phase = 0; m_prev = -1;
        end else begin
            if (load) begin
                m_pend = 1;
                m_pv = int'(period_in);
            end
            if (ena) begin
                m_prev = m_tooth;
                if (m_slot == m_per - 1) begin
                    a = $signed(accel_in);
                    m_per = m_pend ? sat(m_pv) : sat(m_per + a);
                    m_pend = 0;
                    m_tooth = (m_tooth + 1) % TEETH;
                    if (m_tooth == 30) m_phase ^= 1;
                    m_slot = 0;
                end else begin
                    m_slot++;
                end
            end
        end
    endtask

    task automatic check_all();
        bit gap, vr, rev, cam;
        gap = (m_tooth >= TEETH - MISSING);
        vr  = (m_slot >= m_per / 2) && !gap;
        rev = (m_tooth == 0) && (m_slot == 0) && (m_prev == TEETH - 1);
        cam = m_phase && (m_tooth >= 4) && (m_tooth < 54);
        check("tooth_idx", tooth_idx, m_tooth);
        check("period_out", period_out, m_per);
        check("vr_out", vr_out, vr);
        check("gap_out", gap_out, gap);
        check("rev_pulse", rev_pulse, rev);
        check("cam_phase", cam_phase, m_phase);
        check("cam_out", cam_out, cam);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic wait_change(input string tag);
        int last;
        bit seen;
        last = tooth_idx;
        seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            tick();
            if (int'(tooth_idx) != last) seen = 1;
        end
        if (!seen) check({tag, "_timeout"}, 0, 1);
    endtask

    int seq[8];

    task automatic capture(input int n, input string tag);
        int k, last;
        seq[0] = period_out;
        k = 1;
        last = tooth_idx;
        for (int i = 0; i < 3000 && k < n; i++) begin
            tick();
            if (int'(tooth_idx) != last) begin
                last = tooth_idx;
                seq[k] = period_out;
                k++;
            end
        end
        if (k < n) check({tag, "_timeout"}, k, n);
    endtask

    initial begin
        int t1, t2, cnt, snap_t, snap_p, a;
        int exp_up[5];
        int exp_dn[4];
        bit found;
        exp_up = '{8, 9, 10, 10, 10};
        exp_dn = '{10, 7, 5, 5};

        rst = 1'b1; ena = 1'b0; load = 1'b0;
        period_in = '0; accel_in = '0;
        period_min = 16'd2; period_max = 16'hffff;
        tick();
        tick();
        check("rst_tooth", tooth_idx, 45);
        check("rst_period", period_out, 16);
        check("rst_vr", vr_out, 0);
        check("rst_rev", rev_pulse, 0);

        // Wheel timing at a steady 8-clock period.
        rst = 1'b0; ena = 1'b1;
        load = 1'b1; period_in = 16'd8;
        tick();
        load = 1'b0;
        t1 = -1; t2 = -1;
        for (int i = 0; i < 1200; i++) begin
            tick();
            if (rev_pulse) begin
                if (t1 < 0) t1 = i;
                else if (t2 < 0) t2 = i;
            end
        end
        check("rev_interval", t2 - t1, 480);

        // Ramp up into the max clamp, then down into the min clamp.
        period_max = 16'd10;
        accel_in = 16'd1;
        capture(5, "ramp_up");
        for (int i = 0; i < 5; i++) check("ramp_up", seq[i], exp_up[i]);
        period_min = 16'd5;
        accel_in = 16'hfffd;
        capture(4, "ramp_dn");
        for (int i = 0; i < 4; i++) check("ramp_dn", seq[i], exp_dn[i]);

        // Load mid-slot and load competing with accel.
        accel_in = '0; period_min = 16'd2; period_max = 16'd100;
        load = 1'b1; period_in = 16'd8;
        tick();
        load = 1'b0;
        wait_change("ld8");
        repeat (3) tick();
        load = 1'b1; period_in = 16'd20;
        tick();
        load = 1'b0;
        capture(2, "load_mid");
        check("load_cur", seq[0], 8);
        check("load_next", seq[1], 20);
        accel_in = 16'd5;
        repeat (19) tick();
        load = 1'b1; period_in = 16'd12;
        tick();
        load = 1'b0; accel_in = '0;
        check("load_over_accel", period_out, 12);

        // Cam: across two revolutions teeth 4..53 are high exactly once.
        load = 1'b1; period_in = 16'd4;
        tick();
        load = 1'b0;
        found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            tick();
            if (rev_pulse) found = 1;
        end
        if (!found) check("cam_rev_timeout", 0, 1);
        cnt = cam_out;
        for (int i = 1; i < 480; i++) begin
            tick();
            cnt += cam_out;
        end
        check("cam_high_cycles", cnt, 200);

        // Freeze mid-slot for 37 clocks.
        load = 1'b1; period_in = 16'd9;
        tick();
        load = 1'b0;
        wait_change("frz");
        repeat (4) tick();
        snap_t = tooth_idx; snap_p = period_out;
        ena = 1'b0;
        repeat (37) tick();
        check("freeze_tooth", tooth_idx, snap_t);
        check("freeze_period", period_out, snap_p);
        ena = 1'b1;
        repeat (4) tick();
        check("resume_same_slot", tooth_idx, snap_t);
        tick();
        check("resume_next_slot", tooth_idx, (snap_t + 1) % TEETH);

        // Reset in the middle of tooth 10.
        load = 1'b1; period_in = 16'd8;
        tick();
        load = 1'b0;
        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            tick();
            if (tooth_idx == 8'd10) found = 1;
        end
        if (!found) check("t10_timeout", 0, 1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_tooth", tooth_idx, 45);
        check("mid_rst_period", period_out, 16);
        check("mid_rst_phase", cam_phase, 0);
        check("mid_rst_vr", vr_out, 0);

        // Random traffic against the model.
        for (int i = 0; i < 5000; i++) begin
            rst  = ($urandom_range(0, 499) == 0);
            ena  = ($urandom_range(0, 9) != 0);
            load = ($urandom_range(0, 39) == 0);
            period_in = 16'($urandom_range(0, 30));
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 5))
                    0: accel_in = 16'h8000;
                    1: accel_in = 16'h7fff;
                    default: begin
                        a = int'($urandom_range(0, 8)) - 4;
                        accel_in = 16'(a);
                    end
                endcase
            end
            if ($urandom_range(0, 49) == 0) begin
                period_min = 16'($urandom_range(0, 12));
                period_max = 16'($urandom_range(0, 40));
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
